// File: rtl/wb_pipe_stage_if.sv
// Bundle between the MEM stage, the writeback stage register and the register-file write port.
// The master drives the MEM-side signals, and the slave is the writeback stage.
interface wb_pipe_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // Handshake: mem_valid qualifies the MEM-side fields.
  // On an edge with wb_stall=0, the stage accepts them.
  // On an edge with wb_stall=1, everything is held.
  // wb_flush discards the incoming instruction: it clears the stage valid at the edge
  // even while stalled, while the other fields obey wb_stall.
  logic              mem_valid;
  logic              wb_stall;
  logic              wb_flush;
  logic              reg_w_from_MEM;
  logic [1:0]        wb_sel;
  logic [2:0]        ld_type;
  logic [1:0]        ld_addr_lo;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   mem_rdata;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   csr_rdata;
  logic [REG_AW-1:0] rd_addr_from_MEM;
  logic [XLEN-1:0]   wr_back_data;
  logic [REG_AW-1:0] wr_back_addr;
  logic              reg_w_from_wb;
  logic              wb_valid;
  logic              misalign_err;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output mem_valid, wb_stall, wb_flush, reg_w_from_MEM, wb_sel, ld_type, ld_addr_lo,
           alu_res, mem_rdata, pc_plus4, csr_rdata, rd_addr_from_MEM,
    input  wr_back_data, wr_back_addr, reg_w_from_wb, wb_valid, misalign_err, retire_cnt
  );

  modport slave (
    input  mem_valid, wb_stall, wb_flush, reg_w_from_MEM, wb_sel, ld_type, ld_addr_lo,
           alu_res, mem_rdata, pc_plus4, csr_rdata, rd_addr_from_MEM,
    output wr_back_data, wr_back_addr, reg_w_from_wb, wb_valid, misalign_err, retire_cnt
  );
endinterface

// File: rtl/wb_pipe_stage.sv
// Writeback pipeline stage: it registers the MEM results, then aligns and extends load data,
// selects the write-back source, flags misaligned loads and counts retired instructions.
module wb_pipe_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic           clk,
    input logic           rst,
    wb_pipe_stage_if.slave bus
);

    logic              valid_q;
    logic              reg_w_q;
    logic [1:0]        sel_q;
    logic [2:0]        ld_type_q;
    logic [1:0]        lo_q;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   pc4_q;
    logic [XLEN-1:0]   csr_q;
    logic [REG_AW-1:0] rd_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            reg_w_q   <= 1'b0;
            sel_q     <= '0;
            ld_type_q <= '0;
            lo_q      <= '0;
            alu_q     <= '0;
            rdata_q   <= '0;
            pc4_q     <= '0;
            csr_q     <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            if (bus.wb_flush)
                valid_q <= 1'b0;
            else if (!bus.wb_stall)
                valid_q <= bus.mem_valid;
            if (!bus.wb_stall) begin
                reg_w_q   <= bus.reg_w_from_MEM;
                sel_q     <= bus.wb_sel;
                ld_type_q <= bus.ld_type;
                lo_q      <= bus.ld_addr_lo;
                alu_q     <= bus.alu_res;
                rdata_q   <= bus.mem_rdata;
                pc4_q     <= bus.pc_plus4;
                csr_q     <= bus.csr_rdata;
                rd_q      <= bus.rd_addr_from_MEM;
            end
            // Retirement is of the resident instruction, so a flush of the incoming one does not suppress it.
            if (valid_q && !bus.wb_stall)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // funct3 bit 1 set covers LW and the reserved encodings that are treated as LW.
    logic        is_word;
    logic        is_half;
    logic        is_unsigned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_word;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] wb_data;
    logic        misalign;

    assign is_word     = ld_type_q[1];
    assign is_half     = (ld_type_q[1:0] == 2'b01);
    assign is_unsigned = ld_type_q[2];
    assign ld_byte     = rdata_q[{lo_q, 3'b000} +: 8];
    assign ld_half     = rdata_q[{lo_q[1], 4'b0000} +: 16];
    assign ld_word     = rdata_q[31:0];

    always_comb begin
        load_val = '0;
        if (is_word) begin
            load_val       = {XLEN{ld_word[31]}};
            load_val[31:0] = ld_word;
        end else if (is_half) begin
            load_val       = {XLEN{ld_half[15] & ~is_unsigned}};
            load_val[15:0] = ld_half;
        end else begin
            load_val      = {XLEN{ld_byte[7] & ~is_unsigned}};
            load_val[7:0] = ld_byte;
        end
    end

    always_comb begin
        wb_data = alu_q;
        case (sel_q)
            2'b00:   wb_data = alu_q;
            2'b01:   wb_data = load_val;
            2'b10:   wb_data = pc4_q;
            default: wb_data = csr_q;
        endcase
    end

    assign misalign = valid_q && (sel_q == 2'b01) &&
                      ((is_half && lo_q[0]) || (is_word && (lo_q != 2'b00)));

    assign bus.wr_back_data  = wb_data;
    assign bus.wr_back_addr  = rd_q;
    assign bus.reg_w_from_wb = valid_q && reg_w_q && (rd_q != '0) && !misalign;
    assign bus.wb_valid      = valid_q;
    assign bus.misalign_err  = misalign;
    assign bus.retire_cnt    = cnt_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed testbench for wb_pipe_stage: a 32-bit-counter instance for the datapath checks,
// and a 4-bit-counter instance for the wrap check.
module tb_wb_pipe_stage;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_cnt;

  wb_pipe_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) bus ();
  wb_pipe_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(4))  bus4 ();

  wb_pipe_stage #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_pipe_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic vld, input logic regw, input logic [1:0] sel,
                           input logic [2:0] lt, input logic [1:0] lo,
                           input logic [31:0] alu, input logic [31:0] rdata,
                           input logic [31:0] pc4, input logic [31:0] csr,
                           input logic [4:0] rd);
    bus.mem_valid        = vld;
    bus.wb_stall         = 1'b0;
    bus.wb_flush         = 1'b0;
    bus.reg_w_from_MEM   = regw;
    bus.wb_sel           = sel;
    bus.ld_type          = lt;
    bus.ld_addr_lo       = lo;
    bus.alu_res          = alu;
    bus.mem_rdata        = rdata;
    bus.pc_plus4         = pc4;
    bus.csr_rdata        = csr;
    bus.rd_addr_from_MEM = rd;
  endtask

  task automatic set_idle();
    set_instr(1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    bus4.mem_valid = 1'b0; bus4.wb_stall = 1'b0; bus4.wb_flush = 1'b0;
    bus4.reg_w_from_MEM = 1'b1; bus4.wb_sel = 2'b00; bus4.ld_type = 3'b010;
    bus4.ld_addr_lo = 2'b00; bus4.alu_res = 32'h11; bus4.mem_rdata = 32'h0;
    bus4.pc_plus4 = 32'h0; bus4.csr_rdata = 32'h0; bus4.rd_addr_from_MEM = 5'd1;
    #2;
    vectors++; if (bus.wr_back_data !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", bus.wr_back_data); end
    vectors++; if (bus.wr_back_addr !== 5'd0) begin miscompares++; $display("FAIL rst_addr: got %0d want 0", bus.wr_back_addr); end
    vectors++; if (bus.reg_w_from_wb !== 1'b0) begin miscompares++; $display("FAIL rst_regw: got %b want 0", bus.reg_w_from_wb); end
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.wb_valid); end
    vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL rst_misalign: got %b want 0", bus.misalign_err); end
    vectors++; if (bus.retire_cnt !== 32'h0) begin miscompares++; $display("FAIL rst_cnt: got %0d want 0", bus.retire_cnt); end
    @(negedge clk);
    rst = 1'b1;
    step();
    exp_cnt = 32'd0;
  endtask

  task automatic test_lb();
    set_instr(1'b1, 1'b1, 2'b01, 3'b000, 2'b01, 32'h0, 32'h0000_80FF, 32'h0, 32'h0, 5'd5);
    step();
    vectors++; if (bus.wr_back_data !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data: got %h want ffffff80", bus.wr_back_data); end
    vectors++; if (bus.reg_w_from_wb !== 1'b1) begin miscompares++; $display("FAIL lb_regw: got %b want 1", bus.reg_w_from_wb); end
    vectors++; if (bus.wr_back_addr !== 5'd5) begin miscompares++; $display("FAIL lb_addr: got %0d want 5", bus.wr_back_addr); end
    vectors++; if (bus.retire_cnt !== 32'd0) begin miscompares++; $display("FAIL lb_cnt: got %0d want 0", bus.retire_cnt); end
  endtask

  task automatic test_lhu();
    set_instr(1'b1, 1'b1, 2'b01, 3'b101, 2'b10, 32'h0, 32'h8001_0000, 32'h0, 32'h0, 5'd7);
    step();
    vectors++; if (bus.wr_back_data !== 32'h0000_8001) begin miscompares++; $display("FAIL lhu_data: got %h want 00008001", bus.wr_back_data); end
    vectors++; if (bus.misalign_err !== 1'b0) begin miscompares++; $display("FAIL lhu_misalign: got %b want 0", bus.misalign_err); end
    vectors++; if (bus.retire_cnt !== 32'd1) begin miscompares++; $display("FAIL lhu_cnt: got %0d want 1", bus.retire_cnt); end
    bus.ld_addr_lo = 2'b01;
    step();
    vectors++; if (bus.misalign_err !== 1'b1) begin miscompares++; $display("FAIL lhu_mis_flag: got %b want 1", bus.misalign_err); end
    vectors++; if (bus.reg_w_from_wb !== 1'b0) begin miscompares++; $display("FAIL lhu_mis_regw: got %b want 0", bus.reg_w_from_wb); end
    set_idle();
    step();
    vectors++; if (bus.retire_cnt !== 32'd3) begin miscompares++; $display("FAIL lhu_mis_cnt: got %0d want 3", bus.retire_cnt); end
    exp_cnt = 32'd3;
  endtask

  task automatic test_load_variants();
    set_instr(1'b1, 1'b1, 2'b01, 3'b001, 2'b10, 32'h0, 32'h8001_0000, 32'h0, 32'h0, 5'd2);
    step();
    vectors++; if (bus.wr_back_data !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh_data: got %h want ffff8001", bus.wr_back_data); end
    set_instr(1'b1, 1'b1, 2'b01, 3'b100, 2'b01, 32'h0, 32'h0000_80FF, 32'h0, 32'h0, 5'd2);
    step();
    vectors++; if (bus.wr_back_data !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu_data: got %h want 00000080", bus.wr_back_data); end
    set_instr(1'b1, 1'b1, 2'b01, 3'b010, 2'b00, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2);
    step();
    vectors++; if (bus.wr_back_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_data: got %h want deadbeef", bus.wr_back_data); end
    bus.ld_type = 3'b111;
    step();
    vectors++; if (bus.wr_back_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lt111_data: got %h want deadbeef", bus.wr_back_data); end
    bus.ld_addr_lo = 2'b10;
    step();
    vectors++; if (bus.misalign_err !== 1'b1) begin miscompares++; $display("FAIL lt111_misalign: got %b want 1", bus.misalign_err); end
    set_idle();
    step();
    exp_cnt = exp_cnt + 32'd5;
    vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL loads_cnt: got %0d want %0d", bus.retire_cnt, exp_cnt); end
  endtask

  task automatic test_sources();
    set_instr(1'b1, 1'b1, 2'b10, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0000_0104, 32'h0, 5'd0);
    step();
    vectors++; if (bus.wr_back_data !== 32'h0000_0104) begin miscompares++; $display("FAIL pc4_data: got %h want 00000104", bus.wr_back_data); end
    vectors++; if (bus.reg_w_from_wb !== 1'b0) begin miscompares++; $display("FAIL pc4_regw: got %b want 0", bus.reg_w_from_wb); end
    set_instr(1'b1, 1'b1, 2'b11, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 5'd3);
    step();
    vectors++; if (bus.wr_back_data !== 32'h1234_5678) begin miscompares++; $display("FAIL csr_data: got %h want 12345678", bus.wr_back_data); end
    vectors++; if (bus.reg_w_from_wb !== 1'b1) begin miscompares++; $display("FAIL csr_regw: got %b want 1", bus.reg_w_from_wb); end
    set_instr(1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 5'd6);
    step();
    vectors++; if (bus.reg_w_from_wb !== 1'b0) begin miscompares++; $display("FAIL alu_nowrite_regw: got %b want 0", bus.reg_w_from_wb); end
    vectors++; if (bus.wr_back_addr !== 5'd6) begin miscompares++; $display("FAIL alu_nowrite_addr: got %0d want 6", bus.wr_back_addr); end
    set_idle();
    step();
    exp_cnt = exp_cnt + 32'd3;
  endtask

  task automatic test_stall();
    set_instr(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'hA5A5_0001, 32'h0, 32'h0, 32'h0, 5'd9);
    step();
    bus.wb_stall         = 1'b1;
    bus.alu_res          = 32'h0;
    bus.rd_addr_from_MEM = 5'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (bus.wr_back_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL stall_data[%0d]: got %h want a5a50001", i, bus.wr_back_data); end
      vectors++; if (bus.wr_back_addr !== 5'd9) begin miscompares++; $display("FAIL stall_addr[%0d]: got %0d want 9", i, bus.wr_back_addr); end
      vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, bus.retire_cnt, exp_cnt); end
    end
    set_idle();
    step();
    exp_cnt = exp_cnt + 32'd1;
    vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL release_cnt: got %0d want %0d", bus.retire_cnt, exp_cnt); end
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL release_valid: got %b want 0", bus.wb_valid); end
  endtask

  task automatic test_flush();
    set_instr(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000_0AAA, 32'h0, 32'h0, 32'h0, 5'd4);
    step();
    bus.wb_flush = 1'b1;
    bus.wb_stall = 1'b1;
    bus.rd_addr_from_MEM = 5'd8;
    step();
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stall_valid: got %b want 0", bus.wb_valid); end
    vectors++; if (bus.reg_w_from_wb !== 1'b0) begin miscompares++; $display("FAIL flush_stall_regw: got %b want 0", bus.reg_w_from_wb); end
    vectors++; if (bus.wr_back_addr !== 5'd4) begin miscompares++; $display("FAIL flush_stall_addr: got %0d want 4", bus.wr_back_addr); end
    vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL flush_stall_cnt: got %0d want %0d", bus.retire_cnt, exp_cnt); end
    set_instr(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000_0BBB, 32'h0, 32'h0, 32'h0, 5'd10);
    step();
    bus.wb_flush = 1'b1;
    step();
    exp_cnt = exp_cnt + 32'd1;
    vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL flush_retire_cnt: got %0d want %0d", bus.retire_cnt, exp_cnt); end
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_retire_valid: got %b want 0", bus.wb_valid); end
    set_idle();
    step();
    vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL flush_idle_cnt: got %0d want %0d", bus.retire_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    bus4.mem_valid = 1'b1;
    for (int i = 0; i < 16; i++) step();
    vectors++; if (bus4.retire_cnt !== 4'd15) begin miscompares++; $display("FAIL wrap_cnt15: got %0d want 15", bus4.retire_cnt); end
    step();
    vectors++; if (bus4.retire_cnt !== 4'd0) begin miscompares++; $display("FAIL wrap_cnt0: got %0d want 0", bus4.retire_cnt); end
    bus4.mem_valid = 1'b0;
    step();
    vectors++; if (bus4.retire_cnt !== 4'd1) begin miscompares++; $display("FAIL wrap_cnt1: got %0d want 1", bus4.retire_cnt); end
  endtask

  task automatic test_async_reset();
    set_instr(1'b1, 1'b1, 2'b00, 3'b000, 2'b00, 32'h0000_0CCC, 32'h0, 32'h0, 32'h0, 5'd5);
    bus4.mem_valid = 1'b1;
    step();
    bus.wb_stall = 1'b1;
    bus.wb_flush = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    vectors++; if (bus.wr_back_data !== 32'h0) begin miscompares++; $display("FAIL arst_data: got %h want 0", bus.wr_back_data); end
    vectors++; if (bus.wr_back_addr !== 5'd0) begin miscompares++; $display("FAIL arst_addr: got %0d want 0", bus.wr_back_addr); end
    vectors++; if (bus.reg_w_from_wb !== 1'b0) begin miscompares++; $display("FAIL arst_regw: got %b want 0", bus.reg_w_from_wb); end
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b want 0", bus.wb_valid); end
    vectors++; if (bus.retire_cnt !== 32'h0) begin miscompares++; $display("FAIL arst_cnt: got %0d want 0", bus.retire_cnt); end
    vectors++; if (bus4.wb_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid4: got %b want 0", bus4.wb_valid); end
    vectors++; if (bus4.retire_cnt !== 4'd0) begin miscompares++; $display("FAIL arst_cnt4: got %0d want 0", bus4.retire_cnt); end
    step();
    vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL arst_hold_valid: got %b want 0", bus.wb_valid); end
    bus.wb_stall = 1'b0;
    bus.wb_flush = 1'b0;
    #3;
    rst = 1'b1;
    step();
    vectors++; if (bus.wb_valid !== 1'b1) begin miscompares++; $display("FAIL first_cap_valid: got %b want 1", bus.wb_valid); end
    vectors++; if (bus.wr_back_data !== 32'h0000_0CCC) begin miscompares++; $display("FAIL first_cap_data: got %h want 00000ccc", bus.wr_back_data); end
    vectors++; if (bus.retire_cnt !== 32'h0) begin miscompares++; $display("FAIL first_cap_cnt: got %0d want 0", bus.retire_cnt); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = 32'd0;
    test_reset();
    test_lb();
    test_lhu();
    test_load_variants();
    test_sources();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
